// File: rtl/stseq_pkg.sv
// Shared constants and types for the store sequencer and its descriptor table.
package stseq_pkg;

  localparam int REG_W        = 6;   // store-table function index width
  localparam int CPU_W        = 16;  // store register/address width
  localparam int DLY          = 1;   // shared delay constant kept alongside the widths
  localparam int STSEQ_NENT   = 8;   // descriptor-table depth (power of two)
  localparam int STSEQ_GAP_W  = 4;   // inter-issue gap field width
  localparam int STSEQ_ITER_W = 8;   // iteration count width
  localparam int STSEQ_IDX_W  = $clog2(STSEQ_NENT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } st_state_e;

  // One store descriptor: function, base address and trailing idle cycles.
  typedef struct packed {
    logic [REG_W-1:0]       func;
    logic [CPU_W-1:0]       rd1;
    logic [STSEQ_GAP_W-1:0] gap;
  } st_desc_t;

endpackage

// File: rtl/stseq_tbl.sv
// Descriptor register file: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; software programs the table before use.
module stseq_tbl
  import stseq_pkg::*;
(
  input  logic                   clk,
  input  logic                   i_we,
  input  logic [STSEQ_IDX_W-1:0] i_wa,
  input  st_desc_t               i_wdata,
  input  logic [STSEQ_IDX_W-1:0] i_ra,
  output st_desc_t               o_rdata
);

  st_desc_t mem_q [STSEQ_NENT];

  // Write one descriptor per cycle when enabled.
  always_ff @(posedge clk) begin
    if (i_we) begin
      mem_q[i_wa] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_ra];

endmodule

// File: rtl/stseq.sv
// Store sequencer: replays descriptors 0..nent for a number of iterations,
// adding a stride to the addresses on every pass, then waits for the
// store-address unit to drain before pulsing completion.
//
// Handshake: o_ld_st_add_op is a one-cycle valid with no ready; the
// store-address unit must accept every pulse. o_func_st/o_rd1_st are valid
// in the pulse cycle and hold their value afterwards.
module stseq
  import stseq_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_cfg_we,
  input  logic [STSEQ_IDX_W-1:0]  i_cfg_a,
  input  logic [REG_W-1:0]        i_cfg_func,
  input  logic [CPU_W-1:0]        i_cfg_rd1,
  input  logic [STSEQ_GAP_W-1:0]  i_cfg_gap,
  input  logic                    i_start,
  input  logic [STSEQ_IDX_W-1:0]  i_nent,
  input  logic [STSEQ_ITER_W-1:0] i_iter,
  input  logic [CPU_W-1:0]        i_stride,
  input  logic                    i_abort,
  input  logic                    i_st_working,
  output logic                    o_ld_st_add_op,
  output logic [REG_W-1:0]        o_func_st,
  output logic [CPU_W-1:0]        o_rd1_st,
  output logic                    o_busy,
  output logic                    o_done,
  output st_state_e               o_state
);

  st_state_e                 state_q, state_d;
  logic [STSEQ_IDX_W-1:0]    idx_q, idx_d, nent_q, nent_d;
  logic [STSEQ_ITER_W-1:0]   iter_q, iter_d, itcnt_q, itcnt_d;
  logic [CPU_W-1:0]          stride_q, stride_d, off_q, off_d;
  logic [STSEQ_GAP_W-1:0]    gap_q, gap_d;
  logic [1:0]                hold_q, hold_d;
  logic                      op_q, op_d, busy_q, busy_d, done_q, done_d;
  logic [REG_W-1:0]          func_q, func_d;
  logic [CPU_W-1:0]          rd1_q, rd1_d;
  st_desc_t                  rd_ent;
  st_desc_t                  wr_ent;
  logic                      tbl_we;

  // Programming is only accepted while idle so a running replay never sees
  // its descriptors change underneath it.
  assign tbl_we = i_cfg_we && (state_q == ST_IDLE);
  assign wr_ent = '{func: i_cfg_func, rd1: i_cfg_rd1, gap: i_cfg_gap};

  stseq_tbl u_tbl (
    .clk     (clk),
    .i_we    (tbl_we),
    .i_wa    (i_cfg_a),
    .i_wdata (wr_ent),
    .i_ra    (idx_q),
    .o_rdata (rd_ent)
  );

  // Next-state, counters and registered issue outputs.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    nent_d   = nent_q;
    iter_d   = iter_q;
    itcnt_d  = itcnt_q;
    stride_d = stride_q;
    off_d    = off_q;
    gap_d    = gap_q;
    hold_d   = hold_q;
    op_d     = 1'b0;
    func_d   = func_q;
    rd1_d    = rd1_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (i_start && !i_abort) begin
          nent_d   = i_nent;
          iter_d   = (i_iter == '0) ? STSEQ_ITER_W'(1) : i_iter;
          stride_d = i_stride;
          idx_d    = '0;
          itcnt_d  = '0;
          off_d    = '0;
          gap_d    = '0;
          busy_d   = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (gap_q == '0) begin
          op_d   = 1'b1;
          func_d = rd_ent.func;
          rd1_d  = rd_ent.rd1 + off_q;
          gap_d  = rd_ent.gap;
          if (idx_q == nent_q) begin
            idx_d   = '0;
            off_d   = off_q + stride_q;
            itcnt_d = itcnt_q + STSEQ_ITER_W'(1);
            if ((itcnt_q + STSEQ_ITER_W'(1)) == iter_q) begin
              // Two cycles pass between an issue and o_working rising.
              hold_d  = 2'd2;
              state_d = ST_DRAIN;
            end
          end else begin
            idx_d = idx_q + STSEQ_IDX_W'(1);
          end
        end else begin
          gap_d = gap_q - STSEQ_GAP_W'(1);
        end
      end
      ST_DRAIN: begin
        if (hold_q != 2'd0) begin
          hold_d = hold_q - 2'd1;
        end else if (!i_st_working) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Abort wins over everything, including an issue due this cycle.
    if (i_abort) begin
      state_d = ST_IDLE;
      op_d    = 1'b0;
      func_d  = func_q;
      rd1_d   = rd1_q;
      done_d  = 1'b0;
      busy_d  = 1'b0;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      nent_q   <= '0;
      iter_q   <= '0;
      itcnt_q  <= '0;
      stride_q <= '0;
      off_q    <= '0;
      gap_q    <= '0;
      hold_q   <= '0;
      op_q     <= 1'b0;
      func_q   <= '0;
      rd1_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      nent_q   <= nent_d;
      iter_q   <= iter_d;
      itcnt_q  <= itcnt_d;
      stride_q <= stride_d;
      off_q    <= off_d;
      gap_q    <= gap_d;
      hold_q   <= hold_d;
      op_q     <= op_d;
      func_q   <= func_d;
      rd1_q    <= rd1_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign o_ld_st_add_op = op_q;
  assign o_func_st      = func_q;
  assign o_rd1_st       = rd1_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_state        = state_q;

endmodule

// File: tb/tb_stseq.sv
// Scoreboard bench for stseq: the driver predicts every issue (cycle, func,
// address) and the completion cycle from the descriptor rules; a negedge
// monitor pops and compares whenever the DUT pulses.
module tb_stseq;
  import stseq_pkg::*;

  localparam int EW = 32 + REG_W + CPU_W;  // {cycle, func, rd1}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic                    i_cfg_we = 1'b0;
  logic [STSEQ_IDX_W-1:0]  i_cfg_a = '0;
  logic [REG_W-1:0]        i_cfg_func = '0;
  logic [CPU_W-1:0]        i_cfg_rd1 = '0;
  logic [STSEQ_GAP_W-1:0]  i_cfg_gap = '0;
  logic                    i_start = 1'b0;
  logic [STSEQ_IDX_W-1:0]  i_nent = '0;
  logic [STSEQ_ITER_W-1:0] i_iter = '0;
  logic [CPU_W-1:0]        i_stride = '0;
  logic                    i_abort = 1'b0;
  logic                    i_st_working = 1'b0;
  logic                    o_ld_st_add_op, o_busy, o_done;
  logic [REG_W-1:0]        o_func_st;
  logic [CPU_W-1:0]        o_rd1_st;
  st_state_e               o_state;

  stseq dut (
    .clk(clk), .rst_n(rst_n),
    .i_cfg_we(i_cfg_we), .i_cfg_a(i_cfg_a), .i_cfg_func(i_cfg_func),
    .i_cfg_rd1(i_cfg_rd1), .i_cfg_gap(i_cfg_gap),
    .i_start(i_start), .i_nent(i_nent), .i_iter(i_iter), .i_stride(i_stride),
    .i_abort(i_abort), .i_st_working(i_st_working),
    .o_ld_st_add_op(o_ld_st_add_op), .o_func_st(o_func_st), .o_rd1_st(o_rd1_st),
    .o_busy(o_busy), .o_done(o_done), .o_state(o_state)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0]    exp_q[$];
  int               done_exp_q[$];
  logic [REG_W-1:0] m_func [STSEQ_NENT];
  logic [CPU_W-1:0] m_rd1  [STSEQ_NENT];
  int               m_gap  [STSEQ_NENT];
  int n_cmp = 0, n_bad = 0;
  int ts = 0, last_iss = 0, d_cyc = 0, w_low = 0;
  int bfrom = 0, bto = -1;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", {63'd0, o_busy}, {63'd0, (cyc >= bfrom && cyc <= bto)});
      if (o_ld_st_add_op) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_issue", 64'd1, 64'd0);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          chk("issue_cyc",  64'(cyc),       64'(e[EW-1 -: 32]));
          chk("issue_func", 64'(o_func_st), 64'(e[REG_W+CPU_W-1 -: REG_W]));
          chk("issue_rd1",  64'(o_rd1_st),  64'(e[CPU_W-1:0]));
        end
      end
      if (o_done) begin
        if (done_exp_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
        else chk("done_cyc", 64'(cyc), 64'(done_exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    i_start = 1'b0;
    i_cfg_we = 1'b0;
    i_abort = 1'b0;
    if (cyc >= w_low) i_st_working = 1'b0;
  endtask

  task automatic write_cfg(input int a, input logic [REG_W-1:0] f,
                           input logic [CPU_W-1:0] r, input int g);
    step();
    i_cfg_we = 1'b1;
    i_cfg_a = STSEQ_IDX_W'(a);
    i_cfg_func = f;
    i_cfg_rd1 = r;
    i_cfg_gap = STSEQ_GAP_W'(g);
    m_func[a] = f;
    m_rd1[a] = r;
    m_gap[a] = g;
  endtask

  // Start a replay and predict it: issues walk entries 0..nent, each pass
  // shifted by pass*stride, spaced gap+1 apart; done comes no earlier than
  // three cycles after the last issue and after working has gone low.
  task automatic start_run(input int nent, input int iter,
                           input logic [CPU_W-1:0] stride, input int wrel);
    int t, n_it;
    logic [CPU_W-1:0] a;
    step();
    ts = cyc;
    i_start = 1'b1;
    i_nent = STSEQ_IDX_W'(nent);
    i_iter = STSEQ_ITER_W'(iter);
    i_stride = stride;
    i_st_working = (wrel > 0);
    n_it = (iter == 0) ? 1 : iter;
    t = ts + 2;
    for (int it = 0; it < n_it; it++) begin
      for (int e = 0; e <= nent; e++) begin
        a = m_rd1[e] + CPU_W'(it) * stride;
        exp_q.push_back({32'(t), m_func[e], a});
        last_iss = t;
        t = t + m_gap[e] + 1;
      end
    end
    w_low = ts + wrel;
    d_cyc = (last_iss + 3 > w_low + 1) ? last_iss + 3 : w_low + 1;
    done_exp_q.push_back(d_cyc);
    bfrom = ts + 1;
    bto = d_cyc;
  endtask

  task automatic finish_run(input string name);
    while (cyc <= d_cyc + 1) step();
    chk({name, "_issues_left"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_done_left"}, 64'(done_exp_q.size()), 64'd0);
    repeat (2) step();
  endtask

  task automatic prog_basic();
    write_cfg(0, 6'd3, 16'h0100, 0);
    write_cfg(1, 6'd5, 16'h0200, 2);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [EW-1:0] keep[$];
    int a_cyc;

    repeat (3) @(negedge clk);
    chk("rst_op",    64'(o_ld_st_add_op), 64'd0);
    chk("rst_func",  64'(o_func_st), 64'd0);
    chk("rst_rd1",   64'(o_rd1_st), 64'd0);
    chk("rst_busy",  64'(o_busy), 64'd0);
    chk("rst_done",  64'(o_done), 64'd0);
    chk("rst_state", 64'(o_state), 64'(ST_IDLE));
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (2) step();

    // Basic run: working held high for twelve cycles past start.
    prog_basic();
    start_run(1, 2, 16'h0010, 12);
    finish_run("basic");

    // Zero iterations behaves as one.
    write_cfg(0, 6'd9, 16'h1234, 3);
    start_run(0, 0, 16'h0040, 0);
    finish_run("iter0");

    // Address wrap across 2^16.
    write_cfg(0, 6'd7, 16'hFFF8, 1);
    start_run(0, 3, 16'h0010, 0);
    finish_run("wrap");

    // Abort during entry 1's gap: nothing further, no done.
    prog_basic();
    start_run(1, 3, 16'h0010, 0);
    repeat (4) step();
    i_abort = 1'b1;
    a_cyc = cyc;
    keep.delete();
    foreach (exp_q[i]) if (int'(exp_q[i][EW-1 -: 32]) <= a_cyc) keep.push_back(exp_q[i]);
    exp_q = keep;
    done_exp_q.delete();
    bto = a_cyc;
    repeat (12) step();
    chk("abort_state", 64'(o_state), 64'(ST_IDLE));
    chk("abort_issues_left", 64'(exp_q.size()), 64'd0);
    start_run(1, 1, 16'h0010, 0);
    finish_run("after_abort");

    // Start together with abort is ignored.
    step();
    i_start = 1'b1;
    i_abort = 1'b1;
    repeat (5) step();
    chk("start_abort_state", 64'(o_state), 64'(ST_IDLE));

    // Config write and start while busy are dropped.
    prog_basic();
    start_run(1, 2, 16'h0008, 4);
    repeat (2) step();
    i_cfg_we = 1'b1;
    i_cfg_a = '0;
    i_cfg_func = 6'h3F;
    i_cfg_rd1 = 16'hDEAD;
    i_cfg_gap = 4'hF;
    i_start = 1'b1;
    i_nent = 3'd7;
    i_iter = 8'd9;
    i_stride = 16'h1234;
    finish_run("busy_ignore");
    start_run(0, 1, 16'h0000, 0);
    finish_run("tbl_readback");

    // Randomized replays.
    for (int r = 0; r < 6; r++) begin
      for (int e = 0; e < STSEQ_NENT; e++)
        write_cfg(e, REG_W'($urandom), CPU_W'($urandom), int'($urandom_range(0, 3)));
      start_run(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                CPU_W'($urandom), int'($urandom_range(0, 40)));
      finish_run("rand");
    end

    // Reset while draining: outputs clear at once and done never pulses.
    prog_basic();
    start_run(1, 1, 16'h0010, 500);
    while (cyc < last_iss + 5) step();
    chk("pre_rst_state", 64'(o_state), 64'(ST_DRAIN));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bto = cyc - 1;
    done_exp_q.delete();
    w_low = 0;
    #1;
    chk("mid_rst_op",   64'(o_ld_st_add_op), 64'd0);
    chk("mid_rst_func", 64'(o_func_st), 64'd0);
    chk("mid_rst_rd1",  64'(o_rd1_st), 64'd0);
    chk("mid_rst_busy", 64'(o_busy), 64'd0);
    chk("mid_rst_done", 64'(o_done), 64'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("post_rst_state", 64'(o_state), 64'(ST_IDLE));
    repeat (10) step();
    chk("post_rst_issues_left", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout @cyc %0d", cyc);
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
